// File: rtl/riscv_tmr_pkg.sv
// rtl/riscv_tmr_pkg.sv - shared constants and checkpoint entry record for the TMR recovery path
package riscv_tmr_pkg;

  localparam int          CKPT_DEPTH_DEFAULT   = 2;
  localparam logic [31:0] CKPT_BASE_DEFAULT    = 32'h0000_0000;
  localparam logic [2:0]  VOTER_STATE_RECOVERY = 3'b000;

  localparam int CKPT_ENTRY_W = 38;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } ckpt_entry_t;

endpackage

// File: rtl/ckpt_delay_line.sv
// rtl/ckpt_delay_line.sv - rollback window of retired register writes, oldest at DEPTH-1
module ckpt_delay_line
  import riscv_tmr_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_shift,
  input  logic                    i_flush,
  input  logic [CKPT_ENTRY_W-1:0] i_entry,
  output logic [CKPT_ENTRY_W-1:0] o_shifted,
  output logic [1:0]              o_count
);

  ckpt_entry_t r_line [DEPTH];
  logic [1:0]  w_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else if (i_shift) begin
      r_line[0] <= ckpt_entry_t'(i_entry);
      for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) w_count = w_count + {1'b0, r_line[i].valid};
  end

  // Only meaningful on a shift cycle; the top gates it with its own shift enable.
  assign o_shifted = r_line[DEPTH-1];
  assign o_count   = w_count;

endmodule

// File: rtl/recovery_checkpoint_writer.sv
// rtl/recovery_checkpoint_writer.sv - delays retired writes by the rollback window, then commits
// them to a shadow register file and the recovery data memory.
module recovery_checkpoint_writer
  import riscv_tmr_pkg::*;
#(
  parameter int          DEPTH     = CKPT_DEPTH_DEFAULT,
  parameter logic [31:0] CKPT_BASE = CKPT_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        Instr_valid,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_RD,
  input  logic [31:0] WB_Result,
  input  logic        Recovery_mode,
  input  logic [4:0]  Rec_rd_addr,
  output logic [31:0] Rec_rd_data,
  output logic        Ckpt_we,
  output logic [31:0] Ckpt_addr,
  output logic [31:0] Ckpt_wdata,
  output logic [1:0]  Pending_count,
  output logic        Flush_done
);

  logic [31:0] r_shadow [32];
  logic [31:0] r_rd_data;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_flush_done;
  logic        r_rec_was_low;

  logic        w_shift;
  logic        w_rec_rise;
  logic        w_commit;
  ckpt_entry_t w_new;
  ckpt_entry_t w_out;
  logic [CKPT_ENTRY_W-1:0] w_out_bits;
  logic [1:0]  w_count;

  assign w_shift    = Instr_valid & ~Recovery_mode;
  // Cleared by reset, so a recovery already in progress at release is not seen as a new edge.
  assign w_rec_rise = Recovery_mode & r_rec_was_low;

  always_comb begin
    w_new       = '0;
    w_new.valid = WB_RegWrite && (WB_RD != 5'd0);
    w_new.rd    = WB_RD;
    w_new.data  = WB_Result;
  end

  ckpt_delay_line #(
    .DEPTH (DEPTH)
  ) u_delay_line (
    .i_clk     (clk),
    .i_rst_n   (rst_in),
    .i_shift   (w_shift),
    .i_flush   (Recovery_mode),
    .i_entry   (w_new),
    .o_shifted (w_out_bits),
    .o_count   (w_count)
  );

  assign w_out    = ckpt_entry_t'(w_out_bits);
  assign w_commit = w_shift & w_out.valid;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
      r_rd_data     <= '0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_flush_done  <= 1'b0;
      r_rec_was_low <= 1'b0;
    end else begin
      // Read-first: a commit to the same index on this edge is seen one cycle later.
      r_rd_data     <= r_shadow[Rec_rd_addr];
      r_we          <= w_commit;
      r_flush_done  <= w_rec_rise;
      r_rec_was_low <= ~Recovery_mode;
      if (w_commit) begin
        r_shadow[w_out.rd] <= w_out.data;
        r_addr             <= CKPT_BASE + {25'd0, w_out.rd, 2'b00};
        r_wdata            <= w_out.data;
      end
    end
  end

  assign Rec_rd_data   = r_rd_data;
  assign Ckpt_we       = r_we;
  assign Ckpt_addr     = r_addr;
  assign Ckpt_wdata    = r_wdata;
  assign Pending_count = w_count;
  assign Flush_done    = r_flush_done;

endmodule

// File: tb/tb_recovery_checkpoint_writer.sv
// tb/tb_recovery_checkpoint_writer.sv - directed self-checking bench for recovery_checkpoint_writer
module tb_recovery_checkpoint_writer;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        Instr_valid;
  logic        WB_RegWrite;
  logic [4:0]  WB_RD;
  logic [31:0] WB_Result;
  logic        Recovery_mode;
  logic [4:0]  Rec_rd_addr;
  logic [31:0] Rec_rd_data;
  logic        Ckpt_we;
  logic [31:0] Ckpt_addr;
  logic [31:0] Ckpt_wdata;
  logic [1:0]  Pending_count;
  logic        Flush_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  recovery_checkpoint_writer dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .Instr_valid   (Instr_valid),
    .WB_RegWrite   (WB_RegWrite),
    .WB_RD         (WB_RD),
    .WB_Result     (WB_Result),
    .Recovery_mode (Recovery_mode),
    .Rec_rd_addr   (Rec_rd_addr),
    .Rec_rd_data   (Rec_rd_data),
    .Ckpt_we       (Ckpt_we),
    .Ckpt_addr     (Ckpt_addr),
    .Ckpt_wdata    (Ckpt_wdata),
    .Pending_count (Pending_count),
    .Flush_done    (Flush_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [4:0] rd, input logic [31:0] d);
    Instr_valid = 1'b1;
    WB_RegWrite = 1'b1;
    WB_RD       = rd;
    WB_Result   = d;
    step();
    Instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in        = 1'b0;
    Recovery_mode = 1'b0;
    Instr_valid   = 1'b0;
    step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic check_commit(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"}, {31'd0, Ckpt_we}, 32'd1);
    check({tag, "_addr"}, Ckpt_addr, addr);
    check({tag, "_data"}, Ckpt_wdata, data);
  endtask

  initial begin
    rst_in        = 1'b0;
    Instr_valid   = 1'b0;
    WB_RegWrite   = 1'b0;
    WB_RD         = 5'd0;
    WB_Result     = 32'd0;
    Recovery_mode = 1'b0;
    Rec_rd_addr   = 5'd0;
    #1;
    check("rst_we", {31'd0, Ckpt_we}, 32'd0);
    check("rst_addr", Ckpt_addr, 32'd0);
    check("rst_wdata", Ckpt_wdata, 32'd0);
    check("rst_pending", {30'd0, Pending_count}, 32'd0);
    check("rst_flush", {31'd0, Flush_done}, 32'd0);
    check("rst_rddata", Rec_rd_data, 32'd0);
    step();
    rst_in = 1'b1;
    step();

    // Basic commit latency
    retire(5'd5, 32'h11);
    check("b1_we", {31'd0, Ckpt_we}, 32'd0);
    check("b1_pend", {30'd0, Pending_count}, 32'd1);
    retire(5'd6, 32'h22);
    check("b2_we", {31'd0, Ckpt_we}, 32'd0);
    check("b2_pend", {30'd0, Pending_count}, 32'd2);
    retire(5'd7, 32'h33);
    check_commit("b3", 32'h14, 32'h11);
    check("b3_pend", {30'd0, Pending_count}, 32'd2);
    Rec_rd_addr = 5'd5;
    step();
    check("b_idle_we", {31'd0, Ckpt_we}, 32'd0);
    check("b_idle_pend", {30'd0, Pending_count}, 32'd2);
    check("b_rd5", Rec_rd_data, 32'h11);

    // Recovery discards window
    do_reset();
    retire(5'd5, 32'hAA);
    retire(5'd6, 32'hBB);
    check("r_pend_full", {30'd0, Pending_count}, 32'd2);
    Recovery_mode = 1'b1;
    step();
    check("r_we0", {31'd0, Ckpt_we}, 32'd0);
    check("r_flush1", {31'd0, Flush_done}, 32'd1);
    check("r_pend0", {30'd0, Pending_count}, 32'd0);
    Instr_valid = 1'b1;
    WB_RD       = 5'd8;
    WB_Result   = 32'h88;
    Rec_rd_addr = 5'd5;
    step();
    check("r_flush_once", {31'd0, Flush_done}, 32'd0);
    check("r_we1", {31'd0, Ckpt_we}, 32'd0);
    check("r_pend_ign", {30'd0, Pending_count}, 32'd0);
    check("r_rd5", Rec_rd_data, 32'h0);
    Instr_valid   = 1'b0;
    Recovery_mode = 1'b0;
    step();

    // x0 never commits
    do_reset();
    retire(5'd0, 32'hFFFF_FFFF);
    check("z_pend", {30'd0, Pending_count}, 32'd0);
    retire(5'd1, 32'h01);
    retire(5'd2, 32'h02);
    check("z_we", {31'd0, Ckpt_we}, 32'd0);
    Rec_rd_addr = 5'd0;
    retire(5'd3, 32'h03);
    check_commit("z_x1", 32'h04, 32'h01);
    check("z_rd0", Rec_rd_data, 32'h0);

    // Recovery and retire in same cycle with full window
    Instr_valid   = 1'b1;
    WB_RegWrite   = 1'b1;
    WB_RD         = 5'd4;
    WB_Result     = 32'h44;
    Recovery_mode = 1'b1;
    step();
    check("s_we", {31'd0, Ckpt_we}, 32'd0);
    check("s_pend", {30'd0, Pending_count}, 32'd0);
    check("s_flush", {31'd0, Flush_done}, 32'd1);
    Instr_valid   = 1'b0;
    Recovery_mode = 1'b0;
    step();
    retire(5'd10, 32'hA);
    check("s_a_we", {31'd0, Ckpt_we}, 32'd0);
    retire(5'd11, 32'hB);
    check("s_b_we", {31'd0, Ckpt_we}, 32'd0);
    retire(5'd12, 32'hC);
    check_commit("s_c", 32'h28, 32'hA);

    // Same-edge read-first and back-to-back same rd
    do_reset();
    retire(5'd9, 32'h44);
    retire(5'd9, 32'h55);
    retire(5'd1, 32'h01);
    check_commit("f_44", 32'h24, 32'h44);
    Rec_rd_addr = 5'd9;
    retire(5'd1, 32'h02);
    check_commit("f_55", 32'h24, 32'h55);
    check("f_rd_old", Rec_rd_data, 32'h44);
    step();
    check("f_rd_new", Rec_rd_data, 32'h55);

    // Reset mid-stream, released while recovery is still high
    retire(5'd5, 32'h1);
    retire(5'd6, 32'h2);
    retire(5'd7, 32'h3);
    check("m_we_pre", {31'd0, Ckpt_we}, 32'd1);
    Recovery_mode = 1'b1;
    rst_in        = 1'b0;
    #1;
    check("m_we", {31'd0, Ckpt_we}, 32'd0);
    check("m_addr", Ckpt_addr, 32'd0);
    check("m_wdata", Ckpt_wdata, 32'd0);
    check("m_pend", {30'd0, Pending_count}, 32'd0);
    check("m_rddata", Rec_rd_data, 32'd0);
    check("m_flush", {31'd0, Flush_done}, 32'd0);
    step();
    rst_in = 1'b1;
    step();
    check("m_noflush1", {31'd0, Flush_done}, 32'd0);
    step();
    check("m_noflush2", {31'd0, Flush_done}, 32'd0);
    check("m_rd9", Rec_rd_data, 32'd0);
    Recovery_mode = 1'b0;
    step();
    retire(5'd8, 32'h8);
    check("m_r1_we", {31'd0, Ckpt_we}, 32'd0);
    retire(5'd9, 32'h9);
    check("m_r2_we", {31'd0, Ckpt_we}, 32'd0);
    retire(5'd10, 32'h10);
    check_commit("m_r3", 32'h20, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
